// File: rtl/capture_uploader.sv
`default_nettype none
// ============================================================================
// Module   : capture_uploader
// Brief    : Reads N samples from a buffer and streams them as a framed,
//            checksummed packet (AA 55 LEN_H LEN_L D[0..N-1] CSUM) to a UART.
// Revision : 1.0 - initial release
// ============================================================================
module capture_uploader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   sample_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HDR0 = 4'd1,
        HDR1 = 4'd2,
        LENH = 4'd3,
        LENL = 4'd4,
        RD   = 4'd5,
        WAIT = 4'd6,
        DATA = 4'd7,
        CSUM = 4'd8,
        FIN  = 4'd9
    } state_t;

    localparam logic [7:0]    C_SYNC0 = 8'hAA;
    localparam logic [7:0]    C_SYNC1 = 8'h55;
    localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] C_ZERO = '0;

    state_t              r_state;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_idx;
    logic [7:0]          r_csum;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_busy;
    logic                r_done;

    logic [15:0]         w_len;
    logic [ADDR_W:0]     w_idx_nxt;
    logic                w_more;
    logic [7:0]          w_pres_byte;
    state_t              w_pres_next;

    assign w_len     = 16'(r_n);
    assign w_idx_nxt = r_idx + C_ONE;
    assign w_more    = (w_idx_nxt < r_n);

    // Byte and successor for the states that present a fixed/derived byte
    always_comb begin
        w_pres_byte = 8'h00;
        w_pres_next = IDLE;
        case (r_state)
            HDR0: begin
                w_pres_byte = C_SYNC0;
                w_pres_next = HDR1;
            end
            HDR1: begin
                w_pres_byte = C_SYNC1;
                w_pres_next = LENH;
            end
            LENH: begin
                w_pres_byte = w_len[15:8];
                w_pres_next = LENL;
            end
            LENL: begin
                w_pres_byte = w_len[7:0];
                w_pres_next = (r_n != C_ZERO) ? RD : CSUM;
            end
            CSUM: begin
                w_pres_byte = r_csum;
                w_pres_next = FIN;
            end
            default: begin
                w_pres_byte = 8'h00;
                w_pres_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_idx      <= '0;
            r_csum     <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n     <= sample_count;
                        r_idx   <= '0;
                        r_csum  <= 8'h00;
                        r_busy  <= 1'b1;
                        r_state <= HDR0;
                    end
                end
                HDR0, HDR1, LENH, LENL, CSUM: begin
                    // Load the byte on entry, then hold it until accepted
                    if (!r_tx_valid) begin
                        r_tx_data  <= w_pres_byte;
                        r_tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= w_pres_next;
                        if (r_state == LENH || r_state == LENL) begin
                            r_csum <= r_csum + r_tx_data;
                        end
                        if (r_state == LENL && r_n != C_ZERO) begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_idx[ADDR_W-1:0];
                        end
                        if (r_state == CSUM) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_tx_data  <= rd_data;
                    r_tx_valid <= 1'b1;
                    r_csum     <= r_csum + rd_data;
                    r_state    <= DATA;
                end
                DATA: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (w_more) begin
                            r_idx     <= w_idx_nxt;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_idx_nxt[ADDR_W-1:0];
                            r_state   <= RD;
                        end else begin
                            r_state <= CSUM;
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_uploader.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_uploader
// Brief    : Directed self-checking bench for capture_uploader (ADDR_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_uploader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   sample_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    capture_uploader #(.ADDR_W(ADDR_W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_count (sample_count),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Sample buffer: data returned one cycle after the read strobe
    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Monitor, evaluated mid-cycle where inputs and outputs are settled
    logic [7:0] byte_q[$];
    int         rd_cnt    = 0;
    int         done_cnt  = 0;
    int         stall_err = 0;
    int         hits [0:15] = '{default: 0};
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b1;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) byte_q.push_back(tx_data);
        if (rd_en === 1'b1) begin
            rd_cnt        <= rd_cnt + 1;
            hits[rd_addr] <= hits[rd_addr] + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (p_valid && !p_ready && (tx_valid !== 1'b1 || tx_data !== p_data))
            stall_err <= stall_err + 1;
        p_valid <= (tx_valid === 1'b1);
        p_ready <= tx_ready;
        p_data  <= tx_data;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [ADDR_W:0] n);
        start        = 1'b1;
        sample_count = n;
        step();
        start        = 1'b0;
        sample_count = '1;
    endtask

    // Runs until done is seen; in stall mode each byte waits 20 cycles
    task automatic run(input int budget, input bit stall, output bit got);
        int sc;
        sc  = 0;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (!stall)              tx_ready = 1'b1;
            else if (!tx_valid)      begin tx_ready = 1'b0; sc = 0; end
            else if (sc < 20)        begin tx_ready = 1'b0; sc++; end
            else                     tx_ready = 1'b1;
            step();
            if (done === 1'b1) got = 1'b1;
        end
        tx_ready = 1'b1;
    endtask

    task automatic chk_pkt(input string tag, input int base);
        chk({tag, " len"}, byte_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < byte_q.size())
                chk($sformatf("%s byte%0d", tag, k), byte_q[base + k], exp_q[k]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tx_valid"}, tx_valid, 0);
        chk({tag, " tx_data"},  tx_data, 0);
        chk({tag, " rd_en"},    rd_en, 0);
        chk({tag, " rd_addr"},  rd_addr, 0);
        chk({tag, " busy"},     busy, 0);
        chk({tag, " done"},     done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, rd_b, dn_b, st_b;
        int hb [0:15];
        bit got;

        rst_n = 1'b0; start = 1'b0; sample_count = '0; tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // N=3, ready always high
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'hF0;
        base = byte_q.size(); rd_b = rd_cnt; dn_b = done_cnt;
        start_pkt(5'd3);
        chk("n3 busy", busy, 1);
        run(200, 1'b0, got);
        chk("n3 done seen", got, 1);
        step();
        chk("n3 busy clear", busy, 0);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h03, 8'h10, 8'h20, 8'hF0, 8'h23};
        chk_pkt("n3", base);
        chk("n3 rd_en count", rd_cnt - rd_b, 3);
        chk("n3 done pulses", done_cnt - dn_b, 1);

        // N=0: no reads, five bytes
        base = byte_q.size(); rd_b = rd_cnt; dn_b = done_cnt;
        start_pkt(5'd0);
        run(100, 1'b0, got);
        chk("n0 done seen", got, 1);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00};
        chk_pkt("n0", base);
        step();
        chk("n0 rd_en count", rd_cnt - rd_b, 0);
        chk("n0 done pulses", done_cnt - dn_b, 1);

        // N=2 with 20-cycle stalls per byte
        mem[0] = 8'h01; mem[1] = 8'h02;
        base = byte_q.size(); st_b = stall_err;
        start_pkt(5'd2);
        run(600, 1'b1, got);
        chk("stall done seen", got, 1);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h02, 8'h01, 8'h02, 8'h05};
        chk_pkt("stall", base);
        step();
        chk("stall stability violations", stall_err - st_b, 0);

        // N=16 (full address range), D[i]=i
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'(i);
            hb[i]  = hits[i];
        end
        base = byte_q.size();
        start_pkt(5'd16);
        run(400, 1'b0, got);
        chk("n16 done seen", got, 1);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h10};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h88);
        chk_pkt("n16", base);
        step();
        for (int i = 0; i < 16; i++)
            chk($sformatf("n16 addr%0d reads", i), hits[i] - hb[i], 1);

        // Start re-pulsed mid-upload with a different count is ignored
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        base = byte_q.size(); dn_b = done_cnt;
        start_pkt(5'd3);
        run(6, 1'b0, got);
        chk("repulse not done early", got, 0);
        start_pkt(5'd5);
        run(200, 1'b0, got);
        chk("repulse done seen", got, 1);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h19};
        chk_pkt("repulse", base);
        repeat (10) step();
        chk("repulse done pulses", done_cnt - dn_b, 1);
        chk("repulse idle", busy, 0);

        // Reset during the data phase of N=8, then a fresh N=1 packet
        for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i);
        rd_b = rd_cnt; dn_b = done_cnt;
        start_pkt(5'd8);
        for (int i = 0; i < 200 && (rd_cnt - rd_b) < 3; i++) step();
        chk("abort reached data phase", rd_cnt - rd_b, 3);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (5) step();
        chk("abort no done", done_cnt - dn_b, 0);
        chk("abort idle", busy, 0);
        mem[0] = 8'h7F;
        base = byte_q.size();
        start_pkt(5'd1);
        run(100, 1'b0, got);
        chk("fresh done seen", got, 1);
        exp_q = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h7F, 8'h80};
        chk_pkt("fresh", base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
